// File: rtl/misr_pkg.sv
// misr_pkg: shared definitions for the adder response compactor.
//   MISR_W        signature / data word width (Cout plus 4-bit Sum)
//   DEFAULT_POLY  feedback taps for x^5 + x^2 + 1
//   DEFAULT_SEED  signature value loaded at the start of a run
//   state_e       run-control FSM states
//   misr_step     one MISR update: shift left, fold in taps on MSB out, XOR in data
package misr_pkg;

   localparam int unsigned MISR_W = 5;

   localparam logic [MISR_W-1:0] DEFAULT_POLY = 5'h05;
   localparam logic [MISR_W-1:0] DEFAULT_SEED = 5'h00;

   typedef enum logic [1:0] {
      StIdle    = 2'd0,
      StCompact = 2'd1,
      StDone    = 2'd2
   } state_e;

   function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] sig,
                                                   input logic [MISR_W-1:0] d,
                                                   input logic [MISR_W-1:0] poly);
      logic [MISR_W-1:0] fb;
      fb = sig[MISR_W-1] ? poly : '0;
      return {sig[MISR_W-2:0], 1'b0} ^ fb ^ d;
   endfunction

endpackage

// File: rtl/misr_core.sv
// misr_core: 5-bit multiple-input signature register.
// Parameters: SEED (value loaded on reset/load), POLY (feedback taps).
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset, loads SEED
//   load      reload SEED (takes priority over enable)
//   enable    fold d into the signature this cycle
//   d         data word to compact
//   sig       registered signature
//   sig_next  signature the register would take if enabled (for end-of-run compare)
module misr_core
   import misr_pkg::*;
#(
   parameter logic [MISR_W-1:0] SEED = DEFAULT_SEED,
   parameter logic [MISR_W-1:0] POLY = DEFAULT_POLY
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              enable,
   input  logic [MISR_W-1:0] d,
   output logic [MISR_W-1:0] sig,
   output logic [MISR_W-1:0] sig_next
);

   logic [MISR_W-1:0] sig_q;

   always_comb begin
      sig_next = misr_step(sig_q, d, POLY);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q <= SEED;
      end else if (load) begin
         sig_q <= SEED;
      end else if (enable) begin
         sig_q <= sig_next;
      end
   end

   assign sig = sig_q;

endmodule

// File: rtl/adder_misr.sv
// adder_misr: compacts NUM_PATTERNS adder results {Cout, Sum} into a MISR signature and
// compares it with a golden value at the end of the run.
// Optional build macro: MISR_X_MASK_EN adds x_mask; set bits zero the matching data bits.
// Ports:
//   clk, rst      clock and synchronous active-high reset
//   start         begin a run (ignored while a run is in progress)
//   in_valid      sum_in/cout_in carry a result this cycle
//   sum_in        adder Sum
//   cout_in       adder Cout
//   expected_sig  golden signature, sampled on the final accepted pattern
//   x_mask        (MISR_X_MASK_EN only) per-bit data mask
//   busy          run in progress
//   done          run complete, pass valid
//   pass          final signature matched expected_sig
//   signature     current MISR contents
//   count         patterns accepted this run
module adder_misr
   import misr_pkg::*;
#(
   parameter int unsigned       NUM_PATTERNS = 16,
   parameter logic [MISR_W-1:0] SEED         = DEFAULT_SEED,
   parameter logic [MISR_W-1:0] POLY         = DEFAULT_POLY
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              start,
   input  logic                              in_valid,
   input  logic [3:0]                        sum_in,
   input  logic                              cout_in,
   input  logic [MISR_W-1:0]                 expected_sig,
`ifdef MISR_X_MASK_EN
   input  logic [MISR_W-1:0]                 x_mask,
`endif
   output logic                              busy,
   output logic                              done,
   output logic                              pass,
   output logic [MISR_W-1:0]                 signature,
   output logic [$clog2(NUM_PATTERNS+1)-1:0] count
);

   localparam int unsigned CW   = $clog2(NUM_PATTERNS + 1);
   localparam logic [CW-1:0] LAST = CW'(NUM_PATTERNS - 1);

   state_e            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic              pass_q, pass_d;
   logic              load, enable;
   logic [MISR_W-1:0] d;
   logic [MISR_W-1:0] sig_next;

`ifdef MISR_X_MASK_EN
   assign d = {cout_in, sum_in} & ~x_mask;
`else
   assign d = {cout_in, sum_in};
`endif

   misr_core #(
      .SEED (SEED),
      .POLY (POLY)
   ) u_core (
      .clk      (clk),
      .rst      (rst),
      .load     (load),
      .enable   (enable),
      .d        (d),
      .sig      (signature),
      .sig_next (sig_next)
   );

   always_comb begin
      state_d = state_q;
      count_d = count_q;
      pass_d  = pass_q;
      load    = 1'b0;
      enable  = 1'b0;
      unique case (state_q)
         StIdle, StDone: begin
            // A new run reseeds and clears the previous verdict.
            if (start) begin
               state_d = StCompact;
               load    = 1'b1;
               count_d = '0;
               pass_d  = 1'b0;
            end
         end
         StCompact: begin
            if (in_valid) begin
               enable  = 1'b1;
               count_d = count_q + CW'(1);
               if (count_q == LAST) begin
                  state_d = StDone;
                  pass_d  = (sig_next == expected_sig);
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         count_q <= '0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         pass_q  <= pass_d;
      end
   end

   assign busy  = (state_q == StCompact);
   assign done  = (state_q == StDone);
   assign pass  = pass_q;
   assign count = count_q;

endmodule

// File: tb/tb_adder_misr.sv
// tb_adder_misr: scoreboard bench for adder_misr. Two instances: NUM_PATTERNS=2 (dut2) and the
// default 16 (dut16). Stimulus pushes the hand-computed state expected after each accepted word;
// per-instance monitors pop and compare one cycle after every accept.
module tb_adder_misr;

   typedef struct packed {
      logic [4:0] sig;
      logic [4:0] cnt;
      logic       done;
      logic       pass;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       start2, start16, valid2, valid16;
   logic [3:0] sum_in;
   logic       cout_in;
   logic [4:0] exp2, exp16;
   logic [4:0] x_mask;
   logic       busy2, done2, pass2, busy16, done16, pass16;
   logic [4:0] sig2, sig16;
   logic [1:0] count2;
   logic [4:0] count16;
   logic       acc2, acc16;

   int checks = 0;
   int errors = 0;

   exp_t q2[$];
   exp_t q16[$];

   always #5 clk = ~clk;

   adder_misr #(.NUM_PATTERNS(2), .SEED(5'h00), .POLY(5'h05)) dut2 (
      .clk          (clk),
      .rst          (rst),
      .start        (start2),
      .in_valid     (valid2),
      .sum_in       (sum_in),
      .cout_in      (cout_in),
      .expected_sig (exp2),
`ifdef MISR_X_MASK_EN
      .x_mask       (x_mask),
`endif
      .busy         (busy2),
      .done         (done2),
      .pass         (pass2),
      .signature    (sig2),
      .count        (count2)
   );

   adder_misr dut16 (
      .clk          (clk),
      .rst          (rst),
      .start        (start16),
      .in_valid     (valid16),
      .sum_in       (sum_in),
      .cout_in      (cout_in),
      .expected_sig (exp16),
`ifdef MISR_X_MASK_EN
      .x_mask       (x_mask),
`endif
      .busy         (busy16),
      .done         (done16),
      .pass         (pass16),
      .signature    (sig16),
      .count        (count16)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitors: an accept is busy && in_valid at a rising edge; compare on the next falling edge.
   always @(posedge clk) begin
      acc2  <= !rst && busy2 && valid2;
      acc16 <= !rst && busy16 && valid16;
   end

   always @(negedge clk) begin
      exp_t e;
      if (acc2) begin
         if (q2.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut2_unexpected_accept: got accept expected none at %0t", $time);
         end else begin
            e = q2.pop_front();
            check("dut2_sig",   32'(sig2),   32'(e.sig));
            check("dut2_count", 32'(count2), 32'(e.cnt));
            check("dut2_done",  32'(done2),  32'(e.done));
            check("dut2_pass",  32'(pass2),  32'(e.pass));
         end
      end
      if (acc16) begin
         if (q16.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL dut16_unexpected_accept: got accept expected none at %0t", $time);
         end else begin
            e = q16.pop_front();
            check("dut16_sig",   32'(sig16),   32'(e.sig));
            check("dut16_count", 32'(count16), 32'(e.cnt));
            check("dut16_done",  32'(done16),  32'(e.done));
            check("dut16_pass",  32'(pass16),  32'(e.pass));
         end
      end
   end

   // Drive one word on dut2 at the current falling edge and queue its expected result.
   task automatic beat2(input logic [4:0] d, input logic [4:0] s, input logic [4:0] c,
                        input logic dn, input logic ps);
      {cout_in, sum_in} = d;
      valid2 = 1'b1;
      q2.push_back('{sig: s, cnt: c, done: dn, pass: ps});
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; start2 = 1'b0; start16 = 1'b0; valid2 = 1'b0; valid16 = 1'b0;
      sum_in = 4'h0; cout_in = 1'b0; exp2 = 5'h00; exp16 = 5'h00; x_mask = 5'h00;
      repeat (2) @(negedge clk);
      check("rst_busy",   32'(busy2),   32'd0);
      check("rst_done",   32'(done2),   32'd0);
      check("rst_pass",   32'(pass2),   32'd0);
      check("rst_sig",    32'(sig2),    32'h00);
      check("rst_count",  32'(count2),  32'd0);
      check("rst_busy16", 32'(busy16),  32'd0);
      check("rst_count16",32'(count16), 32'd0);
      rst = 1'b0;

      // in_valid in IDLE is ignored
      @(negedge clk); {cout_in, sum_in} = 5'h1F; valid2 = 1'b1;
      @(negedge clk); valid2 = 1'b0;
      check("idle_valid_sig",   32'(sig2),   32'h00);
      check("idle_valid_count", 32'(count2), 32'd0);
      check("idle_valid_busy",  32'(busy2),  32'd0);

      // Run 1: 16 then 03 -> 16, 0A; expected 0A so pass
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0; exp2 = 5'h0A;
      check("run1_busy", 32'(busy2), 32'd1);
      beat2(5'h16, 5'h16, 5'd1, 1'b0, 1'b0);
      @(negedge clk); beat2(5'h03, 5'h0A, 5'd2, 1'b1, 1'b1);
      @(negedge clk); valid2 = 1'b0;
      // in_valid in DONE is ignored
      @(negedge clk); {cout_in, sum_in} = 5'h1F; valid2 = 1'b1;
      @(negedge clk); valid2 = 1'b0;
      check("done_hold_sig",   32'(sig2),   32'h0A);
      check("done_hold_count", 32'(count2), 32'd2);
      check("done_hold_done",  32'(done2),  32'd1);
      check("done_hold_pass",  32'(pass2),  32'd1);
      check("done_hold_busy",  32'(busy2),  32'd0);

      // Run 2: start from DONE, wrong golden value, start pulsed mid-run
      @(negedge clk); start2 = 1'b1; exp2 = 5'h0B;
      @(negedge clk);
      check("restart_done",  32'(done2),  32'd0);
      check("restart_pass",  32'(pass2),  32'd0);
      check("restart_busy",  32'(busy2),  32'd1);
      check("restart_sig",   32'(sig2),   32'h00);
      check("restart_count", 32'(count2), 32'd0);
      start2 = 1'b1;
      beat2(5'h16, 5'h16, 5'd1, 1'b0, 1'b0);
      @(negedge clk); start2 = 1'b0; beat2(5'h03, 5'h0A, 5'd2, 1'b1, 1'b0);
      @(negedge clk); valid2 = 1'b0;
      @(negedge clk);
      check("run2_done", 32'(done2), 32'd1);
      check("run2_pass", 32'(pass2), 32'd0);
      check("run2_sig",  32'(sig2),  32'h0A);

      // Reset after one of two patterns, then a clean run
      @(negedge clk); start2 = 1'b1; exp2 = 5'h0A;
      @(negedge clk); start2 = 1'b0; beat2(5'h16, 5'h16, 5'd1, 1'b0, 1'b0);
      @(negedge clk); valid2 = 1'b0; rst = 1'b1; start2 = 1'b1;
      @(negedge clk); rst = 1'b0; start2 = 1'b0;
      check("abort_busy",  32'(busy2),  32'd0);
      check("abort_count", 32'(count2), 32'd0);
      check("abort_sig",   32'(sig2),   32'h00);
      check("abort_done",  32'(done2),  32'd0);
      @(negedge clk); start2 = 1'b1;
      @(negedge clk); start2 = 1'b0; beat2(5'h16, 5'h16, 5'd1, 1'b0, 1'b0);
      @(negedge clk); beat2(5'h03, 5'h0A, 5'd2, 1'b1, 1'b1);
      @(negedge clk); valid2 = 1'b0;

      // Default instance: 16 zero words with idle gaps
      @(negedge clk); start16 = 1'b1;
      @(negedge clk); start16 = 1'b0;
      for (int i = 0; i < 16; i++) begin
         {cout_in, sum_in} = 5'h00;
         valid16 = 1'b1;
         q16.push_back('{sig: 5'h00, cnt: 5'(i + 1), done: (i == 15), pass: (i == 15)});
         @(negedge clk); valid16 = 1'b0;
         @(negedge clk);
         check("gap_count16", 32'(count16), 32'(i + 1));
         check("gap_busy16",  32'(busy16),  (i == 15) ? 32'd0 : 32'd1);
      end
      check("end16_done", 32'(done16), 32'd1);
      check("end16_pass", 32'(pass16), 32'd1);
      check("end16_sig",  32'(sig16),  32'h00);

`ifdef MISR_X_MASK_EN
      // Fully masked data compacts to the seed
      @(negedge clk); start2 = 1'b1; x_mask = 5'h1F; exp2 = 5'h00;
      @(negedge clk); start2 = 1'b0; beat2(5'h1B, 5'h00, 5'd1, 1'b0, 1'b0);
      @(negedge clk); beat2(5'h07, 5'h00, 5'd2, 1'b1, 1'b1);
      @(negedge clk); valid2 = 1'b0;
      @(negedge clk); x_mask = 5'h00;
`endif

      repeat (3) @(negedge clk);
      check("q2_drained",  32'(q2.size()),  32'd0);
      check("q16_drained", 32'(q16.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
